// File: rtl/mem_stage_sram.sv
// Memory stage plus MEM/WB pipeline register.
// Non-memory operations pass through in one cycle. Loads and stores run as two
// sequential 16-bit accesses to an asynchronous SRAM while `freeze` holds upstream.
module mem_stage_sram #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wbEnIn,
    input  logic        memREnIn,
    input  logic        memWEnIn,
    input  logic [3:0]  destIn,
    input  logic [31:0] aluResIn,
    input  logic [31:0] valRmIn,
    output logic        wbEnOut,
    output logic [3:0]  destOut,
    output logic [31:0] resultOut,
    output logic        freeze,
    output logic [17:0] sramAddr,
    output logic [15:0] sramWData,
    input  logic [15:0] sramRData,
    output logic        sramWE_N
);

    typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_e;

    localparam logic [3:0] LastCnt = 4'(WAIT_CYCLES - 1);

    state_e      r_state;
    state_e      w_state_next;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;
    logic [15:0] r_lo_half;
    logic [15:0] r_hi_half;
    logic        w_req;
    logic        w_store;
    logic        w_last;

    // A simultaneous load+store request is a load; nothing is written.
    assign w_req   = memREnIn | memWEnIn;
    assign w_store = memWEnIn & ~memREnIn;
    assign w_last  = (r_cnt == LastCnt);

    // State and phase counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state logic: IDLE -> LO -> HI -> DONE -> IDLE, each phase WAIT_CYCLES long.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        unique case (r_state)
            StIdle: begin
                w_cnt_next = 4'd0;
                if (w_req) w_state_next = StLo;
            end
            StLo: begin
                if (w_last) begin
                    w_state_next = StHi;
                    w_cnt_next   = 4'd0;
                end else begin
                    w_cnt_next = r_cnt + 4'd1;
                end
            end
            StHi: begin
                if (w_last) begin
                    w_state_next = StDone;
                    w_cnt_next   = 4'd0;
                end else begin
                    w_cnt_next = r_cnt + 4'd1;
                end
            end
            // The request is still present in DONE; it must not restart.
            StDone: begin
                w_state_next = StIdle;
                w_cnt_next   = 4'd0;
            end
            default: begin
                w_state_next = StIdle;
                w_cnt_next   = 4'd0;
            end
        endcase
    end

    // Capture each read halfword at the edge ending its phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lo_half <= 16'd0;
            r_hi_half <= 16'd0;
        end else begin
            if (r_state == StLo && w_last) r_lo_half <= sramRData;
            if (r_state == StHi && w_last) r_hi_half <= sramRData;
        end
    end

    // SRAM drive and freeze; strobe held off on the first cycle so the address settles first.
    always_comb begin
        sramAddr  = 18'd0;
        sramWData = 16'd0;
        sramWE_N  = 1'b1;
        freeze    = 1'b0;
        unique case (r_state)
            StIdle: freeze = w_req;
            StLo: begin
                freeze    = 1'b1;
                sramAddr  = {aluResIn[18:2], 1'b0};
                sramWData = valRmIn[15:0];
                sramWE_N  = ~(w_store && r_cnt != 4'd0);
            end
            StHi: begin
                freeze    = 1'b1;
                sramAddr  = {aluResIn[18:2], 1'b1};
                sramWData = valRmIn[31:16];
                sramWE_N  = ~(w_store && r_cnt != 4'd0);
            end
            StDone: freeze = 1'b0;
            default: freeze = 1'b0;
        endcase
    end

    // MEM/WB register: inserts a bubble while frozen, otherwise latches the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbEnOut   <= 1'b0;
            destOut   <= 4'd0;
            resultOut <= 32'd0;
        end else if (freeze) begin
            wbEnOut <= 1'b0;
        end else begin
            wbEnOut   <= wbEnIn;
            destOut   <= destIn;
            resultOut <= memREnIn ? {r_hi_half, r_lo_half} : aluResIn;
        end
    end

endmodule

// File: tb/tb_mem_stage_sram.sv
// Self-checking bench for mem_stage_sram: directed cases plus randomized
// instruction stream checked against a word-level memory model.
module tb_mem_stage_sram;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        wbEnIn, memREnIn, memWEnIn;
    logic [3:0]  destIn;
    logic [31:0] aluResIn, valRmIn;
    logic        wbEnOut;
    logic [3:0]  destOut;
    logic [31:0] resultOut;
    logic        freeze;
    logic [17:0] sramAddr;
    logic [15:0] sramWData;
    logic [15:0] sramRData;
    logic        sramWE_N;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] sram    [64];
    logic [15:0] ref_mem [64];

    mem_stage_sram #(.WAIT_CYCLES(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .wbEnIn    (wbEnIn),
        .memREnIn  (memREnIn),
        .memWEnIn  (memWEnIn),
        .destIn    (destIn),
        .aluResIn  (aluResIn),
        .valRmIn   (valRmIn),
        .wbEnOut   (wbEnOut),
        .destOut   (destOut),
        .resultOut (resultOut),
        .freeze    (freeze),
        .sramAddr  (sramAddr),
        .sramWData (sramWData),
        .sramRData (sramRData),
        .sramWE_N  (sramWE_N)
    );

    always #5 clk = ~clk;

    // Asynchronous-read SRAM, preloaded with a known pattern while in reset.
    assign sramRData = sram[sramAddr[5:0]];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) sram[i] <= 16'(i * 4951 + 9320);
        end else if (!sramWE_N) begin
            sram[sramAddr[5:0]] <= sramWData;
        end
    end

    task automatic init_ref();
        for (int i = 0; i < 64; i++) ref_mem[i] = 16'(i * 4951 + 9320);
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    endtask

    // Issue one instruction starting just after a falling edge and check every cycle
    // of it plus the registered result. Leaves the bench just after a falling edge.
    task automatic do_op(input logic wb, input logic mr, input logic mw, input logic [3:0] dest,
                         input logic [31:0] alu, input logic [31:0] val);
        int          n, ha, c;
        logic        req, st, e_fr, e_we;
        logic [17:0] e_addr;
        logic [15:0] e_wd;
        logic [31:0] e_res;
        req = mr | mw;
        st  = mw & ~mr;
        ha  = int'(alu[18:2]);
        wbEnIn = wb; memREnIn = mr; memWEnIn = mw; destIn = dest;
        aluResIn = alu; valRmIn = val;
        n = req ? 2 * W + 2 : 1;
        for (int k = 0; k < n; k++) begin
            #1;
            e_fr = 1'b0; e_we = 1'b1; e_addr = 18'd0; e_wd = 16'd0;
            if (req && k <= 2 * W) e_fr = 1'b1;
            if (req && k >= 1 && k <= W) begin
                c = k - 1;
                e_addr = {alu[18:2], 1'b0};
                e_wd   = val[15:0];
                e_we   = !(st && c != 0);
            end else if (req && k > W && k <= 2 * W) begin
                c = k - W - 1;
                e_addr = {alu[18:2], 1'b1};
                e_wd   = val[31:16];
                e_we   = !(st && c != 0);
            end
            check_eq("freeze", {31'd0, freeze}, {31'd0, e_fr});
            check_eq("sramAddr", {14'd0, sramAddr}, {14'd0, e_addr});
            check_eq("sramWData", {16'd0, sramWData}, {16'd0, e_wd});
            check_eq("sramWE_N", {31'd0, sramWE_N}, {31'd0, e_we});
            if (k > 0) check_eq("bubble", {31'd0, wbEnOut}, 32'd0);
            @(negedge clk);
        end
        e_res = mr ? {ref_mem[ha * 2 + 1], ref_mem[ha * 2]} : alu;
        if (st) begin
            ref_mem[ha * 2]     = val[15:0];
            ref_mem[ha * 2 + 1] = val[31:16];
        end
        #1;
        check_eq("wbEnOut", {31'd0, wbEnOut}, {31'd0, wb});
        check_eq("destOut", {28'd0, destOut}, {28'd0, dest});
        check_eq("resultOut", resultOut, e_res);
    endtask

    initial begin
        logic [31:0] a;
        int          kind;
        rst = 1'b1;
        wbEnIn = 1'b0; memREnIn = 1'b0; memWEnIn = 1'b0; destIn = 4'd0;
        aluResIn = 32'd0; valRmIn = 32'd0;
        init_ref();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rst_wbEnOut", {31'd0, wbEnOut}, 32'd0);
        check_eq("rst_destOut", {28'd0, destOut}, 32'd0);
        check_eq("rst_resultOut", resultOut, 32'd0);
        check_eq("rst_sramWE_N", {31'd0, sramWE_N}, 32'd1);
        check_eq("rst_freeze", {31'd0, freeze}, 32'd0);

        // Directed: pass-through, store, load-back, back-to-back, both-enables.
        do_op(1'b1, 1'b0, 1'b0, 4'd3, 32'h1234_5678, 32'd0);
        do_op(1'b0, 1'b0, 1'b1, 4'd0, 32'h0000_0010, 32'hDEAD_BEEF);
        do_op(1'b1, 1'b1, 1'b0, 4'd7, 32'h0000_0010, 32'd0);
        do_op(1'b1, 1'b1, 1'b0, 4'd2, 32'h0000_0014, 32'd0);
        do_op(1'b0, 1'b0, 1'b1, 4'd0, 32'h0000_0018, 32'h0BAD_F00D);
        do_op(1'b1, 1'b0, 1'b0, 4'd5, 32'hA5A5_5A5A, 32'd0);
        do_op(1'b1, 1'b1, 1'b1, 4'd4, 32'h0000_0010, 32'h1111_2222);
        do_op(1'b1, 1'b1, 1'b0, 4'd6, 32'h0000_0010, 32'd0);
        do_op(1'b1, 1'b1, 1'b0, 4'd8, 32'h0000_0018, 32'd0);

        // Random stream; upper and byte-offset address bits are noise.
        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom_range(0, 3));
            a = ($urandom & 32'hFFF8_0003) | (32'($urandom_range(0, 31)) << 2);
            case (kind)
                0: do_op(1'($urandom), 1'b0, 1'b0, 4'($urandom), $urandom, $urandom);
                1: do_op(1'($urandom), 1'b1, 1'b0, 4'($urandom), a, $urandom);
                2: do_op(1'b0, 1'b0, 1'b1, 4'($urandom), a, $urandom);
                default: do_op(1'($urandom), 1'b1, 1'b1, 4'($urandom), a, $urandom);
            endcase
        end

        // Non-zero result before the mid-store reset.
        do_op(1'b1, 1'b0, 1'b0, 4'd9, 32'hCAFE_F00D, 32'd0);

        // Store to 0x10, reset asynchronously during the strobe of the HI phase.
        wbEnIn = 1'b0; memREnIn = 1'b0; memWEnIn = 1'b1; destIn = 4'd0;
        aluResIn = 32'h0000_0010; valRmIn = 32'h1357_9BDF;
        repeat (W + 2) @(negedge clk);
        #1;
        check_eq("hi_strobe", {31'd0, sramWE_N}, 32'd0);
        check_eq("hi_addr", {14'd0, sramAddr}, 32'h9);
        rst = 1'b1;
        #1;
        check_eq("arst_sramWE_N", {31'd0, sramWE_N}, 32'd1);
        check_eq("arst_sramAddr", {14'd0, sramAddr}, 32'd0);
        check_eq("arst_wbEnOut", {31'd0, wbEnOut}, 32'd0);
        check_eq("arst_resultOut", resultOut, 32'd0);
        check_eq("arst_destOut", {28'd0, destOut}, 32'd0);
        check_eq("arst_freeze_req", {31'd0, freeze}, 32'd1);
        memWEnIn = 1'b0;
        #1;
        check_eq("arst_freeze_noreq", {31'd0, freeze}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        init_ref();
        do_op(1'b1, 1'b0, 1'b0, 4'd1, 32'h0F0F_1234, 32'd0);
        do_op(1'b1, 1'b1, 1'b0, 4'd2, 32'h0000_0020, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_stage_sram.md
# mem_stage_sram

Memory stage plus MEM/WB pipeline register of the ARM pipeline. Takes the EX/MEM-registered instruction. Non-memory operations pass through in one cycle. Loads and stores run as two sequential 16-bit accesses to the external asynchronous SRAM, and `freeze` stalls the whole upstream pipeline while they run. Its registered outputs drive the register file's write-back inputs directly (`writeBackEn`, `destWB`, `resultWB`); the register file writes on the falling edge.

## Interface
Parameters:
- `WAIT_CYCLES`, default 2: clock cycles per 16-bit SRAM phase. Legal range is 2..15.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `wbEnIn`  in  1  write-back enable from EX/MEM.
- `memREnIn`  in  1  load request.
- `memWEnIn`  in  1  store request.
- `destIn`  in  4  destination register index.
- `aluResIn`  in  32  ALU result; byte address for memory operations.
- `valRmIn`  in  32  store data.
- `wbEnOut`  out  1  to register file `writeBackEn`.
- `destOut`  out  4  to register file `destWB`.
- `resultOut`  out  32  to register file `resultWB`.
- `freeze`  out  1  high while upstream stages and the EX/MEM register must hold.
- `sramAddr`  out  18  SRAM halfword address.
- `sramWData`  out  16  SRAM write data.
- `sramRData`  in  16  SRAM read data.
- `sramWE_N`  out  1  SRAM write strobe, active-low.

## Operation
- FSM states: IDLE, LO, HI, DONE. A 4-bit phase counter `cnt` runs 0..WAIT_CYCLES-1.
- `req = memREnIn | memWEnIn`. If both are high, the operation is treated as a load and nothing is written.
- IDLE:
  - On `req`, go to LO with `cnt = 0`.
  - Otherwise stay in IDLE.
- LO:
  - `sramAddr = {aluResIn[18:2], 1'b0}`; `sramWData = valRmIn[15:0]`.
  - When `cnt = WAIT_CYCLES-1`, capture `sramRData` into `loHalf` and go to HI with `cnt = 0`.
- HI:
  - `sramAddr = {aluResIn[18:2], 1'b1}`; `sramWData = valRmIn[31:16]`.
  - When `cnt = WAIT_CYCLES-1`, capture `sramRData` into `hiHalf` and go to DONE.
- DONE: go to IDLE unconditionally. The inputs still carry the same request here; it is not restarted.
- `sramWE_N`:
  - 0 only for a store (store-only, no load), in LO or HI, when `cnt != 0`.
  - 1 otherwise. The address is therefore stable one cycle before the strobe.
- `sramAddr` and `sramWData` are 0 in IDLE and DONE.
- `freeze`:
  - 1 in IDLE when `req` is high, and in LO and HI.
  - 0 in DONE, and in IDLE when there is no request.
  - Combinational from state and inputs.
- Output register, rising edge:
  - When `freeze = 0`: `wbEnOut <= wbEnIn`, `destOut <= destIn`, `resultOut <= memREnIn ? {hiHalf, loHalf} : aluResIn`.
  - When `freeze = 1`: `wbEnOut <= 0` (bubble); `destOut` and `resultOut` hold.
- Store data never reaches `resultOut`. A store's `wbEnIn` is forwarded unchanged; upstream keeps it at 0.

## Timing
- Reset (asynchronous, effective mid-access):
  - State IDLE, `cnt`, `loHalf` and `hiHalf` all 0.
  - `wbEnOut` 0, `destOut` 0, `resultOut` 0, `sramAddr` 0, `sramWData` 0, `sramWE_N` 1.
  - `freeze` follows `req` immediately. A store aborted mid-access leaves the SRAM partially written; this is accepted.
- Non-memory operation: outputs are valid 1 edge after the inputs appear; one instruction per cycle.
- Load or store:
  - `freeze` is high for 2·WAIT_CYCLES+1 cycles (the IDLE detect cycle, then LO and HI), then low for the DONE cycle.
  - Outputs update at the edge ending DONE, which is 2·WAIT_CYCLES+2 edges after the request appears.
  - With the default, the request at edge 0 gives `freeze` high for edges 0–5 and the result registered at edge 6.
- Back-to-back memory operations: the next request is seen in the IDLE cycle directly after DONE, with no extra gap.
- `sramRData` is sampled at the rising edge ending the last cycle of each phase. The SRAM must return data within WAIT_CYCLES·Tclk.
- The register file writes at the falling edge after the output register updates. Results are therefore visible to a same-cycle register-file read after the next falling edge.

## Test plan
- Reset during HI of a store (`aluResIn = 32'h0000_0010`) → state IDLE, `sramWE_N = 1`, `wbEnOut = 0`, `resultOut = 0` immediately, without waiting for a clock edge.
- ALU pass-through: `wbEnIn = 1`, `destIn = 4'd3`, `aluResIn = 32'h1234_5678`, no request → next edge gives `wbEnOut = 1`, `destOut = 3`, `resultOut = 32'h1234_5678`; `freeze` never rises.
- Store with `WAIT_CYCLES = 2`: `aluResIn = 32'h0000_0010`, `valRmIn = 32'hDEAD_BEEF`.
  - Address 18'h8 with data 16'hBEEF, then address 18'h9 with data 16'hDEAD.
  - `sramWE_N` is low on exactly the second cycle of each phase.
  - `freeze` is high for 5 cycles; `wbEnOut` stays 0.
- Load from an SRAM model preloaded with 18'h8 = 16'hBEEF and 18'h9 = 16'hDEAD, `destIn = 4'd7`, `wbEnIn = 1` → at edge 6: `resultOut = 32'hDEAD_BEEF`, `destOut = 7`, `wbEnOut = 1` for one cycle only.
- Back-to-back load followed by store, then an ALU operation:
  - No restart in DONE.
  - The second access starts in the IDLE cycle directly after DONE.
  - The ALU result is registered one cycle after the second DONE.
- `memREnIn` and `memWEnIn` both high → `sramWE_N` stays 1 throughout; treated as a load.
